// File: rtl/fft_pkg.sv
// Shared FFT types and sizing constants.
// Used by the input loader, butterfly stages and output reorder.
package fft_pkg;

  localparam int N_POINTS = 32;
  localparam int DATA_W   = 16;
  localparam int LOG2N    = $clog2(N_POINTS);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } ld_state_e;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  function automatic logic [LOG2N-1:0] idx_next(
    input logic [LOG2N-1:0] idx
  );
    return idx + LOG2N'(1);
  endfunction

endpackage

// File: rtl/fft_bitrev.sv
// Bit-reversal of a lane index.
// Combinational; shared by the loader and the output reorder stage.
module fft_bitrev #(
  parameter int LOG2N = 5
) (
  input  logic [LOG2N-1:0] idx,
  output logic [LOG2N-1:0] rev
);

  // Mirror the index bits end for end
  always_comb begin
    rev = '0;
    for (int b = 0; b < LOG2N; b++) begin
      rev[b] = idx[LOG2N-1-b];
    end
  end

endmodule

// File: rtl/fft_input_loader.sv
// FFT input loader: streams samples into the lane register bank.
// Define FFT_LOADER_BITREV_EN to fill lanes in bit-reversed order.
module fft_input_loader #(
  parameter int N_POINTS = fft_pkg::N_POINTS,
  parameter int DATA_W   = fft_pkg::DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_re,
  input  logic [DATA_W-1:0]           in_im,
  output logic [N_POINTS-1:0]         lane_en,
  output logic [DATA_W-1:0]           lane_re,
  output logic [DATA_W-1:0]           lane_im,
  output logic                        frame_valid,
  input  logic                        frame_ready,
  output logic [$clog2(N_POINTS)-1:0] sample_idx
);

  import fft_pkg::*;

  localparam int IDX_W = $clog2(N_POINTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

  ld_state_e            state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_POINTS-1:0]  lane_en_q, lane_en_d;
  logic [DATA_W-1:0]    lane_re_q, lane_re_d;
  logic [DATA_W-1:0]    lane_im_q, lane_im_d;
  logic                 frame_valid_q, frame_valid_d;
  logic [IDX_W-1:0]     lane_idx;
  logic                 accept;

`ifdef FFT_LOADER_BITREV_EN
  fft_bitrev #(
    .LOG2N (IDX_W)
  ) u_bitrev (
    .idx (idx_q),
    .rev (lane_idx)
  );
`else
  assign lane_idx = idx_q;
`endif

  assign in_ready    = (state_q == LOAD);
  assign accept      = in_valid && in_ready;
  assign lane_en     = lane_en_q;
  assign lane_re     = lane_re_q;
  assign lane_im     = lane_im_q;
  assign frame_valid = frame_valid_q;
  assign sample_idx  = idx_q;

  // Next-state: count accepts, strobe one lane, then flush and hold
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    lane_en_d     = '0;
    lane_re_d     = lane_re_q;
    lane_im_d     = lane_im_q;
    frame_valid_d = frame_valid_q;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          idx_d               = idx_q + IDX_W'(1);
          lane_en_d[lane_idx] = 1'b1;
          lane_re_d           = in_re;
          lane_im_d           = in_im;
          if (idx_q == LAST_IDX) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        state_d       = HOLD;
        frame_valid_d = 1'b1;
      end
      HOLD: begin
        if (frame_ready) begin
          state_d       = LOAD;
          frame_valid_d = 1'b0;
        end
      end
      default: begin
        state_d       = LOAD;
        frame_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= LOAD;
      idx_q         <= '0;
      lane_en_q     <= '0;
      lane_re_q     <= '0;
      lane_im_q     <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      lane_en_q     <= lane_en_d;
      lane_re_q     <= lane_re_d;
      lane_im_q     <= lane_im_d;
      frame_valid_q <= frame_valid_d;
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// Randomized bench for fft_input_loader against a frame-level model.
// Honors FFT_LOADER_BITREV_EN for the expected lane order.
module tb_fft_input_loader;

  localparam int N  = 32;
  localparam int DW = 16;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_re;
  logic [DW-1:0] in_im;
  logic [N-1:0]  lane_en;
  logic [DW-1:0] lane_re;
  logic [DW-1:0] lane_im;
  logic          frame_valid;
  logic          frame_ready;
  logic [LW-1:0] sample_idx;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: samples taken this frame, frame flagged, last strobe
  int            m_cnt;
  bit            m_fv;
  logic [N-1:0]  m_en;
  logic [DW-1:0] m_re;
  logic [DW-1:0] m_im;
  logic [DW-1:0] m_bank_re [N];
  logic [DW-1:0] m_bank_im [N];
  logic [DW-1:0] d_bank_re [N];
  logic [DW-1:0] d_bank_im [N];

  fft_input_loader #(
    .N_POINTS (N),
    .DATA_W   (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_re       (in_re),
    .in_im       (in_im),
    .lane_en     (lane_en),
    .lane_re     (lane_re),
    .lane_im     (lane_im),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .sample_idx  (sample_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lane_of(input int i);
    int r;
    r = i;
`ifdef FFT_LOADER_BITREV_EN
    r = 0;
    for (int b = 0; b < LW; b++) begin
      if (((i >> b) & 1) != 0) r = r + (1 << (LW - 1 - b));
    end
`endif
    return r;
  endfunction

  task automatic step(input logic r, input logic v, input logic fr,
                      input logic [DW-1:0] re, input logic [DW-1:0] im);
    bit acc;
    bit filled;
    int ln;
    filled = 0;
    rst = r;
    in_valid = v;
    frame_ready = fr;
    in_re = re;
    in_im = im;
    acc = !r && v && (m_cnt < N);
    @(posedge clk);
    #1;
    m_en = '0;
    if (r) begin
      m_cnt = 0;
      m_fv  = 0;
      m_re  = '0;
      m_im  = '0;
    end else if (acc) begin
      ln = lane_of(m_cnt);
      m_en[ln] = 1'b1;
      m_re = re;
      m_im = im;
      m_bank_re[ln] = re;
      m_bank_im[ln] = im;
      m_cnt++;
    end else if (m_cnt == N && !m_fv) begin
      m_fv = 1;
      filled = 1;
    end else if (m_fv && fr) begin
      m_fv  = 0;
      m_cnt = 0;
    end
    for (int k = 0; k < N; k++) begin
      if (lane_en[k] && $countones(lane_en) == 1) begin
        d_bank_re[k] = lane_re;
        d_bank_im[k] = lane_im;
      end
    end
    chk("in_ready", 64'(in_ready), 64'(m_cnt < N));
    chk("frame_valid", 64'(frame_valid), 64'(m_fv));
    chk("lane_en", 64'(lane_en), 64'(m_en));
    chk("lane_re", 64'(lane_re), 64'(m_re));
    chk("lane_im", 64'(lane_im), 64'(m_im));
    chk("sample_idx", 64'(sample_idx), 64'(m_cnt % N));
    if (filled) begin
      for (int k = 0; k < N; k++) begin
        chk("bank_re", 64'(d_bank_re[k]), 64'(m_bank_re[k]));
        chk("bank_im", 64'(d_bank_im[k]), 64'(m_bank_im[k]));
      end
    end
  endtask

  task automatic rnd_step(input int p_valid, input int p_ready);
    step(1'b0, $urandom_range(99) < p_valid, $urandom_range(99) < p_ready,
         DW'($urandom), DW'($urandom));
  endtask

  initial begin
    int guard;
    m_cnt = 0;
    m_fv  = 0;
    m_en  = '0;
    m_re  = '0;
    m_im  = '0;
    for (int k = 0; k < N; k++) begin
      m_bank_re[k] = '0;
      m_bank_im[k] = '0;
      d_bank_re[k] = '0;
      d_bank_im[k] = '0;
    end
    rst = 1'b1;
    in_valid = 1'b0;
    frame_ready = 1'b0;
    in_re = '0;
    in_im = '0;
    @(negedge clk);

    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b1, 16'h1234, 16'h5678);

    // full frame back to back, re = i, im = -i
    for (int i = 0; i < N; i++) begin
      step(1'b0, 1'b1, 1'b0, DW'(i), DW'(-i));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 16'hdead, 16'hbeef);
    step(1'b0, 1'b0, 1'b1, '0, '0);

    // alternating valid across a frame
    guard = 0;
    while (m_cnt < N && guard < 200) begin
      step(1'b0, guard[0] == 1'b0, 1'b1, DW'($urandom), DW'($urandom));
      guard++;
    end
    chk("alt_frame_done", 64'(m_cnt), 64'(N));

    // long hold, release, then immediate accept to lane 0
    step(1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b1, '0, '0);
    step(1'b0, 1'b1, 1'b0, 16'h0a0a, 16'h0b0b);
    step(1'b0, 1'b1, 1'b0, 16'h0c0c, 16'h0d0d);

    // reset after 12 accepts of a fresh frame
    step(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, DW'(i), DW'(i));
    step(1'b1, 1'b1, 1'b0, 16'hffff, 16'hffff);
    guard = 0;
    while (m_cnt < N && guard < 100) begin
      step(1'b0, 1'b1, 1'b0, DW'($urandom), DW'($urandom));
      guard++;
    end
    chk("post_rst_frame", 64'(m_cnt), 64'(N));
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b1, '0, '0);

    // random traffic with occasional resets
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(299) == 0) step(1'b1, 1'b1, 1'b1, '0, '0);
      else rnd_step(70, 30);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_input_loader.md
Name: fft_input_loader

Overview:
- Upstream stage of the FFT input register bank, which is built from enable registers (one per sample lane, real and imaginary).
- Accepts a stream of complex samples over a valid/ready handshake.
- Drives a broadcast data bus plus one one-hot write-enable strobe per lane.
- After N samples, flags a complete frame to the FFT core and holds off input until the core consumes the frame.

Parameters:
- N_POINTS, 32, FFT size; power of two, >= 2.
- DATA_W, 16, width of each real/imaginary sample component (two's complement).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  loader can accept a sample.
- in_re  input  DATA_W  sample real part.
- in_im  input  DATA_W  sample imaginary part.
- lane_en  output  N_POINTS  one-hot write enable to register bank lanes.
- lane_re  output  DATA_W  broadcast real data to bank.
- lane_im  output  DATA_W  broadcast imaginary data to bank.
- frame_valid  output  1  bank holds a complete frame.
- frame_ready  input  1  FFT core consumes the frame.
- sample_idx  output  log2(N_POINTS)  count of samples accepted in the current frame.

Behaviour:
- One clock domain (clk). rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - state = LOAD, sample_idx = 0.
  - lane_en = 0, lane_re = 0, lane_im = 0.
  - frame_valid = 0.
  - in_ready = 1 in the first cycle after reset is released.
- States:
  - LOAD: in_ready = 1. A sample is accepted on a cycle with in_valid && in_ready. Each accept increments sample_idx. The accept of sample N_POINTS-1 moves to FLUSH; sample_idx wraps to 0.
  - FLUSH: exactly one cycle. in_ready = 0. Lets the last strobe land in the bank. Goes to HOLD unconditionally.
  - HOLD: in_ready = 0, frame_valid = 1. On frame_ready = 1, goes to LOAD next cycle, and frame_valid drops in that same cycle.
- in_ready is a pure decode of state, with no combinational path from in_valid or frame_ready.
- Write path, 1-cycle latency:
  - An accept at cycle t drives lane_re/lane_im = the captured sample and lane_en = one-hot(lane(sample_idx)) during cycle t+1.
  - lane_en is 0 on every cycle not following an accept. It is never multi-hot.
- Timing of the last sample: if the last accept is at cycle t, its strobe is at t+1 (FLUSH) and frame_valid first asserts at t+2.
- lane_re/lane_im hold their last value when lane_en = 0.
- Back-to-back accepts give one strobe per cycle. in_valid gaps in LOAD simply pause the count.
- frame_ready asserted outside HOLD is ignored.
- A frame_ready arriving in the first HOLD cycle is legal and gives a 1-cycle frame_valid pulse.
- A new frame's first accept is possible on the cycle after the HOLD handshake.
- Reset mid-frame discards the partial frame: count returns to 0 and no strobe is issued in the cycle after reset. Bank contents are don't-care until the next frame_valid.

Optional Feature:
- Macro: FFT_LOADER_BITREV_EN.
- Defined: lane(i) = bit-reverse of i over log2(N_POINTS) bits, so the bank is filled in the order required by Cooley-Tukey radix-2 DIT. For N_POINTS = 32, sample 1 goes to lane 16 and sample 3 to lane 24.
- Undefined: lane(i) = i, natural order.
- sample_idx always reports the natural count in both builds.

Decomposition:
- Shared package fft_pkg holds:
  - N_POINTS, DATA_W, LOG2N = $clog2(N_POINTS).
  - Loader state enum {LOAD, FLUSH, HOLD}.
  - Complex sample struct {re, im}, reused by the butterfly stages.
- Sub-module fft_bitrev (combinational, parameter LOG2N, idx in → rev out) computes the lane index. It is also reused by the output reorder stage.

Test Plan:
- Release reset, then 32 consecutive valid samples (re = i, im = -i), frame_ready = 0:
  - lane_en pulses one-hot at cycles 1..32 after the first accept.
  - frame_valid rises 2 cycles after the last accept.
  - in_ready = 0 while frame_valid is held.
- Same stimulus with FFT_LOADER_BITREV_EN defined:
  - sample 1 → lane_en = 1<<16; sample 3 → 1<<24; sample 31 → 1<<31.
  - Bank readback equals the bit-reversed order.
- in_valid toggled 1,0,1,0 across the frame:
  - exactly 32 strobes total, none on idle cycles.
  - sample_idx advances only on accepts.
- HOLD with frame_ready held 0 for 10 cycles, then 1 for one cycle:
  - frame_valid stays high throughout, then drops.
  - in_ready = 1 next cycle.
  - a new sample is accepted immediately, with its strobe on lane 0.
- rst asserted after 12 accepts:
  - next cycle sample_idx = 0, lane_en = 0, frame_valid = 0.
  - a following full 32-sample frame completes normally.
